// File: rtl/timer_bank.sv
// Bank of NCH independent down-counting timers behind a simple register port.
// Each channel has CTRL/LOAD/COUNT/STATUS. The per-channel interrupts are ORed onto irq.
module timer_bank #(
   parameter int NCH = 4,
   parameter int AW  = 8,
   parameter int DW  = 32,
   parameter int CW  = 32
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   output logic          wr_err,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          rd_err,
   output logic          irq,
   output logic [NCH-1:0] irq_vec
);

   localparam logic [AW-3:0] PEND_WORD = (AW-2)'(NCH*4);
   localparam logic [DW-1:0] BAD_DATA  = DW'(32'hDEADBEEF);

   logic [2:0]    ctrl  [NCH];
   logic [CW-1:0] load  [NCH];
   logic [CW-1:0] count [NCH];
   logic [NCH-1:0] exp;

   logic [AW-3:0]  wr_word, rd_word;
   logic           wr_in_ch, rd_in_ch, wr_bad, rd_bad;
   logic [NCH-1:0] ctrl_we, load_we, stat_we, expire, start;
   logic [DW-1:0]  rd_val;

   // Byte-address bits [1:0] are ignored, so decoding works on word indices.
   assign wr_word  = wr_addr[AW-1:2];
   assign rd_word  = rd_addr[AW-1:2];
   assign wr_in_ch = wr_word < PEND_WORD;
   assign rd_in_ch = rd_word < PEND_WORD;
   assign wr_bad   = wr_en && !(wr_in_ch && wr_word[1:0] != 2'd2);
   assign wr_ready = 1'b1;

   always_comb begin
      ctrl_we = '0;
      load_we = '0;
      stat_we = '0;
      expire  = '0;
      start   = '0;
      for (int c = 0; c < NCH; c++) begin
         if (wr_en && wr_in_ch && wr_word[AW-3:2] == (AW-4)'(c)) begin
            ctrl_we[c] = wr_word[1:0] == 2'd0;
            load_we[c] = wr_word[1:0] == 2'd1;
            stat_we[c] = wr_word[1:0] == 2'd3;
         end
         expire[c] = ctrl[c][0] && count[c] == '0;
         start[c]  = ctrl_we[c] && wr_data[0] && !ctrl[c][0];
      end
   end

   always_comb begin
      rd_val = BAD_DATA;
      rd_bad = 1'b1;
      if (rd_word == PEND_WORD) begin
         rd_val = DW'(irq_vec);
         rd_bad = 1'b0;
      end else if (rd_in_ch) begin
         for (int c = 0; c < NCH; c++) begin
            if (rd_word[AW-3:2] == (AW-4)'(c)) begin
               rd_bad = 1'b0;
               case (rd_word[1:0])
                  2'd0:    rd_val = DW'(ctrl[c]);
                  2'd1:    rd_val = DW'(load[c]);
                  2'd2:    rd_val = DW'(count[c]);
                  default: rd_val = DW'(exp[c]);
               endcase
            end
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NCH; c++) irq_vec[c] = exp[c] & ctrl[c][2];
   end
   assign irq = |irq_vec;

   // Decisions use register values from before the edge; a software CTRL write
   // overrides the hardware EN clear, and an expiry overrides a W1C.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            ctrl[c]  <= '0;
            load[c]  <= '0;
            count[c] <= '0;
         end
         exp      <= '0;
         wr_err   <= 1'b0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_data  <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (ctrl_we[c])
               ctrl[c] <= wr_data[2:0];
            else if (expire[c] && !ctrl[c][1])
               ctrl[c][0] <= 1'b0;

            if (load_we[c])
               load[c] <= wr_data[CW-1:0];

            if (start[c])
               count[c] <= load[c];
            else if (expire[c]) begin
               if (ctrl[c][1]) count[c] <= load[c];
            end else if (ctrl[c][0])
               count[c] <= count[c] - CW'(1);

            if (expire[c])
               exp[c] <= 1'b1;
            else if (stat_we[c] && wr_data[0])
               exp[c] <= 1'b0;
         end
         wr_err   <= wr_bad;
         rd_valid <= rd_en;
         rd_err   <= rd_en && rd_bad;
         if (rd_en) rd_data <= rd_val;
      end
   end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: table vectors, directed timer sequences,
// and randomized traffic compared against a behavioural model of the register map.
module tb_timer_bank;

   localparam int NCH = 4;

   logic        clk = 1'b0;
   logic        rst, wr_en, rd_en;
   logic [7:0]  wr_addr, rd_addr;
   logic [31:0] wr_data, rd_data;
   logic        wr_ready, wr_err, rd_valid, rd_err, irq;
   logic [3:0]  irq_vec;

   int n_cmp = 0;
   int n_bad = 0;

   timer_bank #(.NCH(4), .AW(8), .DW(32), .CW(32)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .wr_err(wr_err),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_err(rd_err),
      .irq(irq), .irq_vec(irq_vec)
   );

   always #5 clk = ~clk;

   // behavioural model state
   logic [2:0]  m_ctrl  [NCH];
   logic [31:0] m_load  [NCH];
   logic [31:0] m_count [NCH];
   logic        m_exp   [NCH];
   logic [31:0] m_rd_data;
   logic        m_rd_valid, m_rd_err, m_wr_err;

   typedef struct {
      logic        we;
      logic [7:0]  wa;
      logic [31:0] wd;
      logic        re;
      logic [7:0]  ra;
      logic        e_werr;
      logic        e_valid;
      logic [31:0] e_data;
      logic        e_err;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [3:0] m_irq();
      logic [3:0] v;
      for (int c = 0; c < NCH; c++) v[c] = m_exp[c] & m_ctrl[c][2];
      return v;
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a, output logic err);
      int w;
      w = int'(a) >> 2;
      err = 1'b0;
      if (w < NCH*4) begin
         int c;
         c = w / 4;
         case (w % 4)
            0:       return {29'd0, m_ctrl[c]};
            1:       return m_load[c];
            2:       return m_count[c];
            default: return {31'd0, m_exp[c]};
         endcase
      end
      if (w == NCH*4) return {28'd0, m_irq()};
      err = 1'b1;
      return 32'hDEADBEEF;
   endfunction

   task automatic model_edge(input logic r, input logic we, input logic [7:0] wa,
                             input logic [31:0] wd, input logic re, input logic [7:0] ra);
      int wi;
      logic e;
      if (r) begin
         for (int c = 0; c < NCH; c++) begin
            m_ctrl[c] = 0; m_load[c] = 0; m_count[c] = 0; m_exp[c] = 0;
         end
         m_rd_data = 0; m_rd_valid = 0; m_rd_err = 0; m_wr_err = 0;
         return;
      end
      wi = int'(wa) >> 2;
      m_rd_valid = re;
      m_rd_err   = 1'b0;
      if (re) begin
         m_rd_data = m_read(ra, e);
         m_rd_err  = e;
      end
      m_wr_err = we && !(wi < NCH*4 && (wi % 4) != 2);
      for (int c = 0; c < NCH; c++) begin
         logic        hit_ctrl, hit_load, hit_stat, fired;
         logic [31:0] prev_load;
         hit_ctrl  = we && wi == c*4;
         hit_load  = we && wi == c*4 + 1;
         hit_stat  = we && wi == c*4 + 3;
         prev_load = m_load[c];
         fired     = 1'b0;
         if (hit_ctrl && wd[0] && !m_ctrl[c][0])
            m_count[c] = prev_load;
         else if (m_ctrl[c][0] && m_count[c] != 0)
            m_count[c] = m_count[c] - 1;
         else if (m_ctrl[c][0]) begin
            fired = 1'b1;
            if (m_ctrl[c][1]) m_count[c] = prev_load;
            else m_ctrl[c][0] = 1'b0;
         end
         if (hit_ctrl) m_ctrl[c] = wd[2:0];
         if (hit_load) m_load[c] = wd;
         if (fired) m_exp[c] = 1'b1;
         else if (hit_stat && wd[0]) m_exp[c] = 1'b0;
      end
   endtask

   // One clock: drive at the falling edge, check just after the rising edge.
   task automatic step(input logic r, input logic we, input logic [7:0] wa,
                       input logic [31:0] wd, input logic re, input logic [7:0] ra);
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
      model_edge(r, we, wa, wd, re, ra);
      @(posedge clk);
      #1;
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rd_valid});
      chk("rd_data", rd_data, m_rd_data);
      chk("rd_err", {31'd0, rd_err}, {31'd0, m_rd_err});
      chk("wr_err", {31'd0, wr_err}, {31'd0, m_wr_err});
      chk("irq_vec", {28'd0, irq_vec}, {28'd0, m_irq()});
      chk("irq", {31'd0, irq}, {31'd0, |m_irq()});
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, 8'h00);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      step(0, 1, a, d, 0, 8'h00);
   endtask

   task automatic rd(input logic [7:0] a);
      step(0, 0, 8'h00, 0, 1, a);
   endtask

   initial begin
      tbl[0]  = '{1, 8'h04, 32'h12345678, 1, 8'h04, 0, 1, 32'h0, 0};
      tbl[1]  = '{0, 8'h00, 32'h0,        1, 8'h04, 0, 1, 32'h12345678, 0};
      tbl[2]  = '{1, 8'h00, 32'hFFFFFFF8, 1, 8'h00, 0, 1, 32'h0, 0};
      tbl[3]  = '{0, 8'h00, 32'h0,        1, 8'h00, 0, 1, 32'h0, 0};
      tbl[4]  = '{1, 8'h08, 32'h5,        1, 8'h08, 1, 1, 32'h0, 0};
      tbl[5]  = '{1, 8'h40, 32'h1,        1, 8'h40, 1, 1, 32'h0, 0};
      tbl[6]  = '{1, 8'h14, 32'hA5,       1, 8'h44, 0, 1, 32'hDEADBEEF, 1};
      tbl[7]  = '{1, 8'hFC, 32'h1,        1, 8'hFC, 1, 1, 32'hDEADBEEF, 1};
      tbl[8]  = '{1, 8'h2C, 32'h1,        1, 8'h3C, 0, 1, 32'h0, 0};
      tbl[9]  = '{0, 8'h00, 32'h0,        1, 8'h17, 0, 1, 32'hA5, 0};
      tbl[10] = '{0, 8'h00, 32'h0,        0, 8'h00, 0, 0, 32'hA5, 0};

      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_addr = 0; rd_addr = 0; wr_data = 0;
      @(negedge clk);
      step(1, 0, 8'h00, 0, 0, 8'h00);
      step(1, 0, 8'h00, 0, 0, 8'h00);
      chk("reset_rd_data", rd_data, 32'h0);
      chk("reset_irq", {28'd0, irq_vec}, 32'h0);
      chk("wr_ready", {31'd0, wr_ready}, 32'h1);

      for (int i = 0; i < 11; i++) begin
         step(0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
         chk($sformatf("tbl%0d_werr", i), {31'd0, wr_err}, {31'd0, tbl[i].e_werr});
         chk($sformatf("tbl%0d_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].e_valid});
         chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].e_data);
         chk($sformatf("tbl%0d_err", i), {31'd0, rd_err}, {31'd0, tbl[i].e_err});
      end

      // one-shot on channel 0: expiry LOAD+1 edges after enabling
      wr(8'h04, 32'd5);
      wr(8'h00, 32'h5);
      idle(5);
      chk("oneshot_before", {31'd0, irq}, 32'h0);
      idle(1);
      chk("oneshot_irq", {31'd0, irq}, 32'h1);
      rd(8'h00);
      chk("oneshot_en_cleared", rd_data, 32'h4);
      rd(8'h08);
      chk("oneshot_count", rd_data, 32'h0);
      wr(8'h0C, 32'h1);
      chk("oneshot_w1c", {31'd0, irq}, 32'h0);

      // auto-reload on channel 1: expiry every 4 edges; set beats clear
      wr(8'h14, 32'd3);
      wr(8'h10, 32'h3);
      idle(3);
      step(0, 1, 8'h1C, 32'h1, 1, 8'h1C);
      chk("ar_pre_exp", rd_data, 32'h0);
      step(0, 1, 8'h1C, 32'h1, 1, 8'h1C);
      chk("ar_set_beats_clr", rd_data, 32'h1);
      rd(8'h1C);
      chk("ar_cleared", rd_data, 32'h0);
      idle(2);
      rd(8'h1C);
      chk("ar_reexpired", rd_data, 32'h1);
      wr(8'h10, 32'h0);
      wr(8'h1C, 32'h1);

      // channels 0 and 2 together
      wr(8'h04, 32'd2);
      wr(8'h24, 32'd7);
      wr(8'h00, 32'h5);
      wr(8'h20, 32'h5);
      idle(2);
      chk("multi_ch0", {28'd0, irq_vec}, 32'h1);
      idle(5);
      chk("multi_ch0_only", {28'd0, irq_vec}, 32'h1);
      idle(1);
      chk("multi_both", {28'd0, irq_vec}, 32'h5);
      rd(8'h40);
      chk("irq_pend", rd_data, 32'h5);
      wr(8'h0C, 32'h1);
      wr(8'h2C, 32'h1);
      chk("multi_cleared", {28'd0, irq_vec}, 32'h0);

      // freeze and resume on channel 3, plus write to read-only COUNT
      wr(8'h34, 32'd10);
      wr(8'h30, 32'h1);
      idle(3);
      wr(8'h30, 32'h0);
      idle(2);
      rd(8'h38);
      chk("freeze_count", rd_data, 32'd6);
      wr(8'h38, 32'h99);
      chk("count_ro_err", {31'd0, wr_err}, 32'h1);
      rd(8'h38);
      chk("count_ro_keep", rd_data, 32'd6);
      wr(8'h30, 32'h1);
      rd(8'h38);
      chk("resume_reload", rd_data, 32'd10);

      // reset while counting
      wr(8'h34, 32'd100);
      wr(8'h30, 32'h7);
      idle(3);
      step(1, 0, 8'h00, 0, 0, 8'h00);
      step(1, 0, 8'h00, 0, 0, 8'h00);
      chk("rst_irq", {31'd0, irq}, 32'h0);
      rd(8'h38);
      chk("rst_count", rd_data, 32'h0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'h1);
      rd(8'h34);
      chk("rst_load", rd_data, 32'h0);

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         logic        r, we, re;
         logic [7:0]  wa, ra;
         logic [31:0] wd;
         r  = ($urandom_range(0, 149) == 0);
         we = $urandom_range(0, 1);
         re = $urandom_range(0, 1);
         wa = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 16) * 4 + $urandom_range(0, 3));
         ra = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 16) * 4 + $urandom_range(0, 3));
         wd = $urandom;
         if (((wa >> 2) % 4) == 1) wd = $urandom_range(0, 12);
         step(r, we, wa, wd, re, ra);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
